// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared types and constants for the clock-divider scheduler.
//            Holds the scheduler state encoding, the smallest legal divide
//            ratio and the default sizing constants.
// Revision : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    // Scheduler states: stopped, running, finishing the current period
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A ratio of 1 (or 0) cannot produce both a high and a low phase
    localparam int MIN_DIV     = 2;

    localparam int DEF_DIV_W   = 8;
    localparam int DEF_DEF_DIV = 4;
    localparam int DEF_CNT_W   = 16;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : clk_phase_cnt
// Purpose  : Modulo-N phase counter. While run is high, ph counts
//            0..div-1 and wraps; wrap flags the last phase of a period.
//            While run is low, ph is held at 0.
// Revision : 1.0  initial release
// ============================================================================
module clk_phase_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] ph,
    output logic             wrap
);

    localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

    logic [DIV_W-1:0] ph_q;
    logic [DIV_W-1:0] ph_d;

    assign wrap = run && (ph_q == (div - C_ONE));
    assign ph   = ph_q;

    // Next phase: advance while running, restart at the period boundary
    always_comb begin
        ph_d = '0;
        if (run && !wrap) begin
            ph_d = ph_q + C_ONE;
        end
    end

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

endmodule : clk_phase_cnt
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Purpose  : Run/stop controller and ratio scheduler for the divided clock.
//            Produces a registered divided clock (clk_out), a period-start
//            pulse (tick) and a period counter. New ratios arrive over a
//            valid/ready handshake and take effect only at period
//            boundaries (or straight away while idle), so clk_out never
//            shows a runt phase.
//            Optional feature macro: CLK_DIV_SCHED_DUTY_EN adds a
//            programmable high-phase length (cfg_high).
// Revision : 1.0  initial release
// ============================================================================
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_DEF_DIV,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef CLK_DIV_SCHED_DUTY_EN
    input  logic [DIV_W-1:0] cfg_high,
`endif
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] period_cnt
);

    localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] C_MIN     = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] C_DEF_DIV = DIV_W'(DEF_DIV);

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] div_cur_q;
    logic [DIV_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             cfg_err_q;
    logic [CNT_W-1:0] period_cnt_q;

    logic [DIV_W-1:0] ph;
    logic [DIV_W-1:0] ph_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] high_nxt;
    logic             run;
    logic             wrap;
    logic             accept;
    logic             bad;
    logic             apply;
    logic             clk_out_d;
    logic             tick_d;

    assign run = (state_q != IDLE);

    clk_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .div   (div_cur_q),
        .ph    (ph),
        .wrap  (wrap)
    );

    // Phase the counter will hold after this edge; outputs are registered
    // from it so they line up with ph without skew.
    assign ph_nxt = (run && !wrap) ? (ph + C_ONE) : '0;

    // accept and apply are mutually exclusive (ready only when nothing is
    // pending), so a ratio is never applied in the cycle it is accepted.
    assign accept  = cfg_valid && !pend_vld_q;
    assign apply   = pend_vld_q && (!run || wrap);
    assign div_nxt = apply ? pend_q : div_cur_q;

`ifdef CLK_DIV_SCHED_DUTY_EN
    logic [DIV_W-1:0] pend_high_q;
    logic [DIV_W-1:0] high_cur_q;

    assign bad      = (cfg_div < C_MIN) || (cfg_high == '0) || (cfg_high >= cfg_div);
    assign high_nxt = apply ? pend_high_q : high_cur_q;

    // High-phase length: captured with the ratio, switched in with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_high_q <= '0;
            high_cur_q  <= C_DEF_DIV >> 1;
        end else begin
            if (accept && !bad) begin
                pend_high_q <= cfg_high;
            end
            if (apply) begin
                high_cur_q <= pend_high_q;
            end
        end
    end
`else
    assign bad      = (cfg_div < C_MIN);
    assign high_nxt = div_nxt >> 1;
`endif

    // Next-state decode and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        clk_out_d = (state_d != IDLE) && (ph_nxt < high_nxt);
        tick_d    = (state_d != IDLE) && (ph_nxt == '0);
    end

    // FSM, ratio handshake and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_cur_q    <= C_DEF_DIV;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            period_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            div_cur_q    <= div_nxt;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            cfg_err_q    <= accept && bad;
            period_cnt_q <= period_cnt_q + {{(CNT_W-1){1'b0}}, tick_d};
            if (accept && !bad) begin
                pend_q     <= cfg_div;
                pend_vld_q <= 1'b1;
            end else if (apply) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign cfg_ready  = !pend_vld_q;
    assign cfg_err    = cfg_err_q;
    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign running    = run;
    assign period_cnt = period_cnt_q;

endmodule : clk_div_sched
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Purpose  : Self-checking bench for clk_div_sched: directed vector table,
//            hand-written corner sequences and randomized traffic compared
//            against a period-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_sched;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
`ifdef CLK_DIV_SCHED_DUTY_EN
    logic [DIV_W-1:0] cfg_high = '0;
`endif
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] period_cnt;

    clk_div_sched #(
        .DIV_W   (DIV_W),
        .DEF_DIV (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
`ifdef CLK_DIV_SCHED_DUTY_EN
        .cfg_high   (cfg_high),
`endif
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- reference model (period level) ----------------
    bit m_active, m_drain, m_pend_ok, m_err, m_clk, m_tick;
    int m_pos, m_N, m_high, m_pend, m_phigh, m_cnt;

    task automatic model_reset();
        m_active = 0; m_drain = 0; m_pend_ok = 0; m_err = 0;
        m_clk = 0; m_tick = 0; m_pos = 0; m_N = 4; m_high = 2;
        m_pend = 0; m_phigh = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d, input int h);
        bit last, acc, bad, app;
        last = m_active && (m_pos == m_N - 1);
        acc  = v && !m_pend_ok;
        bad  = (d < 2);
`ifdef CLK_DIV_SCHED_DUTY_EN
        bad  = bad || (h == 0) || (h >= d);
`endif
        app  = m_pend_ok && (!m_active || last);
        if (app) begin
            m_N = m_pend;
`ifdef CLK_DIV_SCHED_DUTY_EN
            m_high = m_phigh;
`else
            m_high = m_pend / 2;
`endif
        end
        if (!m_active) begin
            m_active = e; m_drain = 0; m_pos = 0;
        end else begin
            m_pos = last ? 0 : m_pos + 1;
            if (e) m_drain = 0;
            else if (m_drain && last) begin m_active = 0; m_drain = 0; end
            else m_drain = 1;
        end
        m_err = acc && bad;
        if (acc && !bad) begin m_pend = d; m_phigh = h; m_pend_ok = 1; end
        else if (app) m_pend_ok = 0;
        m_tick = m_active && (m_pos == 0);
        if (m_tick) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_clk = m_active && (m_pos < m_high);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, advance DUT and model, settle 1ns after edge
    task automatic cyc(input bit e, input bit v, input int d, input int h);
        en = e; cfg_valid = v; cfg_div = d[DIV_W-1:0];
`ifdef CLK_DIV_SCHED_DUTY_EN
        cfg_high = h[DIV_W-1:0];
`endif
        @(posedge clk);
        model_step(e, v, d, h);
        #1;
    endtask

    task automatic chk_model();
        chk("clk_out",    int'(clk_out),    int'(m_clk));
        chk("tick",       int'(tick),       int'(m_tick));
        chk("running",    int'(running),    int'(m_active));
        chk("cfg_ready",  int'(cfg_ready),  int'(!m_pend_ok));
        chk("cfg_err",    int'(cfg_err),    int'(m_err));
        chk("period_cnt", int'(period_cnt), m_cnt);
    endtask

    task automatic mcyc(input bit e, input bit v, input int d, input int h);
        cyc(e, v, d, h);
        chk_model();
    endtask

    typedef struct {
        bit en; bit v; int div;
        bit x_clk; bit x_tick; bit x_run; bit x_rdy; bit x_err; int x_cnt;
    } vec_t;

    vec_t tbl[16];
    bit   pat4[4];

    initial begin
        int prev;
        bit seen;
        // en, valid, div | clk_out, tick, running, cfg_ready, cfg_err, period_cnt
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 1, 1, 1, 0, 1};
        tbl[2]  = '{1, 0, 0, 1, 0, 1, 1, 0, 1};
        tbl[3]  = '{1, 1, 3, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 1, 1, 1, 1, 0, 2};
        tbl[6]  = '{1, 0, 0, 0, 0, 1, 1, 0, 2};
        tbl[7]  = '{1, 0, 0, 0, 0, 1, 1, 0, 2};
        tbl[8]  = '{1, 0, 0, 1, 1, 1, 1, 0, 3};
        tbl[9]  = '{1, 1, 1, 0, 0, 1, 1, 1, 3};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 1, 0, 3};
        tbl[11] = '{1, 0, 0, 1, 1, 1, 1, 0, 4};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 1, 0, 4};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 1, 0, 4};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 4};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 4};
        pat4[0] = 1; pat4[1] = 1; pat4[2] = 0; pat4[3] = 0;

        // ---- reset state ----
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out",    int'(clk_out),    0);
        chk("rst_tick",       int'(tick),       0);
        chk("rst_running",    int'(running),    0);
        chk("rst_cfg_ready",  int'(cfg_ready),  1);
        chk("rst_cfg_err",    int'(cfg_err),    0);
        chk("rst_period_cnt", int'(period_cnt), 0);
        rst_n = 1'b1;

        // ---- directed vector table ----
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].en, tbl[i].v, tbl[i].div, tbl[i].div / 2);
            chk($sformatf("tbl%0d_clk_out", i),    int'(clk_out),    int'(tbl[i].x_clk));
            chk($sformatf("tbl%0d_tick", i),       int'(tick),       int'(tbl[i].x_tick));
            chk($sformatf("tbl%0d_running", i),    int'(running),    int'(tbl[i].x_run));
            chk($sformatf("tbl%0d_cfg_ready", i),  int'(cfg_ready),  int'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d_cfg_err", i),    int'(cfg_err),    int'(tbl[i].x_err));
            chk($sformatf("tbl%0d_period_cnt", i), int'(period_cnt), tbl[i].x_cnt);
        end

        // ---- drain then re-raise en: no gap in the waveform ----
        mcyc(0, 1, 4, 2);                      // ratio 4 applied while idle
        mcyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) mcyc(1, 0, 0, 0);
        mcyc(0, 0, 0, 0);                      // enter DRAIN
        for (int i = 0; i < 8; i++) begin
            mcyc(1, 0, 0, 0);
            chk("drain_reraise_running", int'(running), 1);
        end
        // let it drain out to idle
        for (int i = 0; i < 6; i++) mcyc(0, 0, 0, 0);
        chk("drained_idle", int'(running), 0);

        // ---- asynchronous reset mid-period with a pending ratio ----
        for (int i = 0; i < 2; i++) mcyc(1, 0, 0, 0);
        mcyc(1, 1, 6, 3);
        mcyc(1, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("arst_clk_out",    int'(clk_out),    0);
        chk("arst_tick",       int'(tick),       0);
        chk("arst_running",    int'(running),    0);
        chk("arst_cfg_ready",  int'(cfg_ready),  1);
        chk("arst_period_cnt", int'(period_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mcyc(1, 0, 0, 0);
            chk("post_rst_pattern", int'(clk_out), int'(pat4[i % 4]));
        end

        // ---- period counter wrap at N=2 ----
        mcyc(1, 1, 2, 1);
        prev = int'(period_cnt);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            mcyc(1, 0, 0, 0);
            if (prev == 15 && period_cnt == 0) seen = 1;
            prev = int'(period_cnt);
        end
        chk("period_cnt_wrap_seen", int'(seen), 1);

`ifdef CLK_DIV_SCHED_DUTY_EN
        // ---- programmable duty: N=5 high=1, then an illegal high ----
        for (int i = 0; i < 4; i++) mcyc(0, 0, 0, 0);
        mcyc(0, 1, 5, 1);
        mcyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            mcyc(1, 0, 0, 0);
            chk("duty_pattern", int'(clk_out), (i % 5 == 0) ? 1 : 0);
        end
        mcyc(1, 1, 5, 5);
        chk("duty_bad_high_err", int'(cfg_err), 1);
        mcyc(1, 0, 0, 0);
`endif

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 800; i++) begin
            bit e, v;
            int d, h;
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) == 0);
            d = $urandom_range(0, 9);
            h = $urandom_range(0, d + 1);
            mcyc(e, v, d, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_clk_div_sched
`default_nettype wire

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Run/stop controller and ratio scheduler for the team's clock-divider counter.
- Sequences a programmable divide-by-N phase counter and emits a registered divided clock (clk_out) plus a period-start pulse (tick).
- Accepts new divide ratios through a valid/ready handshake and applies them only at period boundaries, so clk_out never produces a runt phase.
- Sits between the configuration/control logic and every consumer of the divided clock or clock-enable.

Parameters:
- DIV_W, 8, width of divide ratio and phase counter.
- DEF_DIV, 4, ratio loaded at reset; must be 2..2^DIV_W-1.
- CNT_W, 16, width of the period counter.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  run request (level).
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  DIV_W  requested ratio N.
- cfg_ready  out  1  ratio can be accepted.
- cfg_err  out  1  one-cycle pulse: offered ratio rejected.
- clk_out  out  1  registered divided clock.
- tick  out  1  registered pulse, high during phase 0 of every period.
- running  out  1  state != IDLE.
- period_cnt  out  CNT_W  number of periods started.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on assertion: state=IDLE, ph=0, div_cur=DEF_DIV, pend_vld=0, clk_out=0, tick=0, cfg_err=0, period_cnt=0; cfg_ready=1.
- FSM has three states.
  - IDLE: en=1 -> RUN. On the first RUN cycle ph=0, clk_out=1, tick=1.
  - RUN: ph counts 0..div_cur-1 and wraps to 0 at div_cur-1. en=0 -> DRAIN (ph keeps counting).
  - DRAIN: at ph==div_cur-1 go to IDLE, with clk_out=0 and tick=0 from the next cycle. en=1 during DRAIN -> back to RUN with no discontinuity in ph.
- Waveform: clk_out=1 when ph < div_cur>>1, else 0. clk_out and tick are registered from next-state/next-ph values, giving zero-cycle skew to ph. clk_out=0 in IDLE.
- Handshake: cfg_ready = !pend_vld. A transfer happens when cfg_valid && cfg_ready.
  - cfg_div < 2: rejected. cfg_err=1 the next cycle; pend is unchanged.
  - Otherwise: pend <= cfg_div, pend_vld <= 1.
- Applying a pending ratio: div_cur <= pend and pend_vld <= 0.
  - RUN/DRAIN: at the boundary cycle (ph==div_cur-1), so the next period uses the new N.
  - IDLE: on the cycle after acceptance.
- Simultaneous accept and boundary: the pre-existing pend (if any) is applied. The newly accepted value waits for the next boundary; it is never applied in the same cycle it is accepted.
- period_cnt increments on every tick cycle and wraps 2^CNT_W-1 -> 0. Only reset clears it.
- Reset mid-period: outputs drop on the reset edge with no drain, and any pending ratio is discarded.

Optional Feature:
- Macro CLK_DIV_SCHED_DUTY_EN.
- Defined:
  - Adds input port cfg_high [DIV_W], captured with cfg_div into pend_high.
  - clk_out=1 when ph < high_cur.
  - The offer is rejected (cfg_err) if cfg_high==0 or cfg_high>=cfg_div.
  - high_cur resets to DEF_DIV>>1.
- Undefined: no cfg_high port; high phase is fixed at div_cur>>1.

Decomposition:
- Package clk_div_pkg holds:
  - the state typedef (IDLE, RUN, DRAIN);
  - MIN_DIV=2;
  - default DIV_W/DEF_DIV constants.
- One sub-module, clk_phase_cnt: a modulo-N phase counter.
  - Inputs: clk, rst_n, run, div.
  - Outputs: ph, wrap.
- FSM, handshake and output registers stay in clk_div_sched.

Test Plan:
- Defaults, en=1 at cycle 5 -> from cycle 6: clk_out pattern 1,1,0,0 repeating; tick at cycles 6,10,14; period_cnt 1,2,3.
- Running N=4, cfg_div=3 offered at ph=1 -> cfg_ready low next cycle; current period completes 1,1,0,0; then 1,0,0 repeating; cfg_ready returns high after the boundary.
- cfg_div=1 offered -> cfg_err pulse one cycle; pattern stays 1,1,0,0; cfg_ready stays 1.
- en=0 at ph=1 (N=4) -> ph 2,3 complete (clk_out 0,0), then IDLE, running=0, clk_out=0. Separately, re-raising en during DRAIN -> no gap in the pattern.
- rst_n low for 1 cycle mid-period with pending cfg_div=6 -> all outputs 0 at once. After release with en=1: pattern 1,1,0,0 (DEF_DIV); pending 6 is discarded.
- CNT_W=4, run 17 periods at N=2 -> period_cnt goes 15 -> 0 -> 1. With CLK_DIV_SCHED_DUTY_EN: N=5, high=1 gives pattern 1,0,0,0,0; high=5 gives cfg_err.
